// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache: combinational lookup for the fetch stage, line refill over a valid/ready bus.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module icache_responder #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pcF,
  input  logic        stallF,
  input  logic        inv,
  output logic [31:0] instrF,
  output logic        icache_stall,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int WI_W  = $clog2(WORDS);
  localparam int LI_W  = $clog2(LINES);
  localparam int TAG_W = 32 - 2 - WI_W - LI_W;
  localparam int LA_W  = 30 - WI_W;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] REFILL = 2'd2;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]       state, state_next;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES*WORDS];
  logic [LA_W-1:0]  req_line;
  logic [WI_W-1:0]  beat;
  logic             inv_pending;

  logic [WI_W-1:0]  pc_word;
  logic [LI_W-1:0]  pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic [LI_W-1:0]  req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit, miss, beat_en, last_beat;
  logic             unused_bits;

  assign pc_word = pcF[WI_W+1:2];
  assign pc_idx  = pcF[LI_W+WI_W+1:WI_W+2];
  assign pc_tag  = pcF[31:LI_W+WI_W+2];
  assign req_idx = req_line[LI_W-1:0];
  assign req_tag = req_line[LA_W-1:LI_W];

  assign hit       = (state == IDLE) && valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign miss      = (state == IDLE) && !hit;
  assign beat_en   = (state == REFILL) && mem_rsp_valid;
  assign last_beat = beat_en && (beat == WI_W'(WORDS - 1));

  // Anything other than an IDLE hit holds fetch and feeds it a NOP.
  assign icache_stall  = !hit;
  assign instrF        = hit ? data_mem[{pc_idx, pc_word}] : NOP;
  assign mem_req_valid = (state == REQ);
  assign mem_req_addr  = {req_line, {(WI_W + 2){1'b0}}};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (miss) state_next = REQ;
      REQ:     if (mem_req_ready) state_next = REFILL;
      REFILL:  if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // An invalidate seen at any point of a miss must keep that refill from marking its line valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_line    <= '0;
      beat        <= '0;
      inv_pending <= 1'b0;
    end else begin
      state <= state_next;
      if (miss) begin
        req_line    <= pcF[31:WI_W+2];
        inv_pending <= inv;
      end else if (state != IDLE && inv) begin
        inv_pending <= 1'b1;
      end
      if (state == REQ)
        beat <= '0;
      else if (beat_en)
        beat <= beat + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      valid <= '0;
    else if (inv)
      valid <= '0;
    else if (last_beat && !inv_pending)
      valid[req_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (beat_en)
      data_mem[{req_idx, beat}] <= mem_rsp_data;
    if (last_beat)
      tag_mem[req_idx] <= req_tag;
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit && !stallF)
        hit_cnt <= hit_cnt + 32'd1;
      if (miss)
        miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign unused_bits = ^pcF[1:0];
`else
  assign unused_bits = ^{pcF[1:0], stallF};
`endif

endmodule
